// File: rtl/led_pkg.sv
// Shared constants and helpers for the LED sequencer / PWM dimmer path.
// Colour-bit indices are common to the sequencer and dimmer.
package led_pkg;
   localparam int          LED_DUTY_W       = 8;
   localparam logic [7:0]  LED_DUTY_FULL    = 8'hFF;
   localparam int          LED_CLK_HZ       = 12_000_000;
   localparam int          LED_TICK_HZ      = 250_000;
   localparam int          LED_PRESCALE_DIV = LED_CLK_HZ / LED_TICK_HZ - 1;
   localparam int          LED_NUM_CH       = 3;
   localparam int          LED_IDX_R        = 2;
   localparam int          LED_IDX_G        = 1;
   localparam int          LED_IDX_B        = 0;

   typedef logic [LED_DUTY_W-1:0] duty_t;

   // One LSB toward the target, never past it.
   function automatic duty_t step_toward(input duty_t cur, input duty_t tgt);
      if (cur < tgt)      return cur + duty_t'(1);
      else if (cur > tgt) return cur - duty_t'(1);
      else                return cur;
   endfunction
endpackage

// File: rtl/led_pwm_dimmer_channel.sv
// One colour channel: latched level/target, fade stepping and PWM compare.
// Levels only move at period boundaries so a period is never cut short.
module led_pwm_channel
   import led_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  enable,
   input  logic  boundary,
   input  logic  fade_en,
   input  logic  fade_step,
   input  duty_t pwm_cnt,
   input  duty_t duty,
   input  logic  led_in,
   output logic  led,
   output logic  busy
);
   duty_t cur, tgt;
   logic  raw;

   assign raw  = led_in && (cur == LED_DUTY_FULL || pwm_cnt < cur);
   assign busy = (cur != tgt);

   always_ff @(posedge clk) begin
      if (rst) begin
         cur <= '0;
         tgt <= '0;
         led <= 1'b0;
      end else begin
         if (boundary) begin
            tgt <= duty;
            if (!fade_en)      cur <= duty;
            else if (fade_step) cur <= step_toward(cur, duty);
         end
         led <= enable && raw;
      end
   end
endmodule

// File: rtl/led_pwm_dimmer.sv
// Three-channel PWM dimmer between the colour sequencer and the pads.
// Prescaler, PWM counter and fade divider are shared by all channels.
module led_pwm_dimmer
   import led_pkg::*;
#(
   parameter int PRESCALE_DIV      = LED_PRESCALE_DIV,
   parameter int FADE_STEP_PERIODS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       led_r_in,
   input  logic       led_g_in,
   input  logic       led_b_in,
   input  logic [7:0] duty_r,
   input  logic [7:0] duty_g,
   input  logic [7:0] duty_b,
   input  logic       fade_en,
   output logic       led_r,
   output logic       led_g,
   output logic       led_b,
   output logic       period_start,
   output logic       fade_busy
);
   localparam int PW = $clog2(PRESCALE_DIV + 2);
   localparam int FW = $clog2(FADE_STEP_PERIODS + 1);

   logic [PW-1:0] presc;
   logic [FW-1:0] fdiv;
   duty_t         pwm_cnt;
   logic          tick, boundary, fade_step;

   logic [LED_NUM_CH-1:0][LED_DUTY_W-1:0] duty_all;
   logic [LED_NUM_CH-1:0]                 led_in_all, led_all, busy_all;

   assign tick      = enable && (presc == PW'(PRESCALE_DIV));
   assign boundary  = tick && (pwm_cnt == LED_DUTY_FULL);
   assign fade_step = boundary && (fdiv == FW'(FADE_STEP_PERIODS - 1));

   always_comb begin
      duty_all   = '0;
      led_in_all = '0;
      duty_all[LED_IDX_R]   = duty_r;
      duty_all[LED_IDX_G]   = duty_g;
      duty_all[LED_IDX_B]   = duty_b;
      led_in_all[LED_IDX_R] = led_r_in;
      led_in_all[LED_IDX_G] = led_g_in;
      led_in_all[LED_IDX_B] = led_b_in;
   end

   assign led_r = led_all[LED_IDX_R];
   assign led_g = led_all[LED_IDX_G];
   assign led_b = led_all[LED_IDX_B];

   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         presc   <= '0;
         pwm_cnt <= '0;
         fdiv    <= '0;
      end else begin
         presc <= tick ? '0 : presc + PW'(1);
         if (tick) pwm_cnt <= pwm_cnt + duty_t'(1);
         // Divider only runs while fading; a fresh ramp starts a full step away.
         if (!fade_en)      fdiv <= '0;
         else if (fade_step) fdiv <= '0;
         else if (boundary)  fdiv <= fdiv + FW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         period_start <= 1'b0;
         fade_busy    <= 1'b0;
      end else begin
         period_start <= boundary;
         fade_busy    <= |busy_all;
      end
   end

   for (genvar ch = 0; ch < LED_NUM_CH; ch++) begin : g_ch
      led_pwm_channel u_ch (
         .clk       (clk),
         .rst       (rst),
         .enable    (enable),
         .boundary  (boundary),
         .fade_en   (fade_en),
         .fade_step (fade_step),
         .pwm_cnt   (pwm_cnt),
         .duty      (duty_all[ch]),
         .led_in    (led_in_all[ch]),
         .led       (led_all[ch]),
         .busy      (busy_all[ch])
      );
   end
endmodule

// File: tb/tb_led_pwm_dimmer.sv
// Directed bench for led_pwm_dimmer with a one-clock tick and one-period fade step.
module tb_led_pwm_dimmer;
   logic       clk = 1'b0;
   logic       rst, enable, led_r_in, led_g_in, led_b_in, fade_en;
   logic [7:0] duty_r, duty_g, duty_b;
   logic       led_r, led_g, led_b, period_start, fade_busy;

   int n_pass = 0, n_total = 0;

   led_pwm_dimmer #(.PRESCALE_DIV(0), .FADE_STEP_PERIODS(1)) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .led_r_in(led_r_in), .led_g_in(led_g_in), .led_b_in(led_b_in),
      .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b), .fade_en(fade_en),
      .led_r(led_r), .led_g(led_g), .led_b(led_b),
      .period_start(period_start), .fade_busy(fade_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] dr, dg, db;
      logic [2:0] in_rgb;
      int         er, eg, eb;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Advance at least one cycle, then stop on the next period_start cycle.
   task automatic wait_ps(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!period_start && n < 600);
      if (n >= 600) chk("period_start_timeout", n, 0);
   endtask

   // Called on a period_start cycle; measures that period and ends on the next one.
   task automatic count_period(output int hr, output int hg, output int hb,
                               output int ps, output int fr, output int busy_end);
      hr = 0; hg = 0; hb = 0; ps = 0; fr = -1; busy_end = 0;
      for (int i = 1; i <= 256; i++) begin
         @(negedge clk);
         if (led_r) begin
            hr++;
            if (fr < 0) fr = i;
         end
         if (led_g) hg++;
         if (led_b) hb++;
         if (period_start) ps++;
         if (i == 256) busy_end = int'(fade_busy);
      end
   endtask

   initial begin
      int hr, hg, hb, ps, fr, be, n;
      int fade_w[5]    = '{1, 2, 3, 4, 4};
      int fade_b[5]    = '{1, 1, 1, 0, 0};

      vecs[0] = '{dr: 8'd64,  dg: 8'd255, db: 8'd0,   in_rgb: 3'b111, er: 64,  eg: 256, eb: 0};
      vecs[1] = '{dr: 8'd64,  dg: 8'd0,   db: 8'd128, in_rgb: 3'b111, er: 64,  eg: 0,   eb: 128};
      vecs[2] = '{dr: 8'd1,   dg: 8'd255, db: 8'd254, in_rgb: 3'b101, er: 1,   eg: 0,   eb: 254};
      vecs[3] = '{dr: 8'd255, dg: 8'd128, db: 8'd255, in_rgb: 3'b110, er: 256, eg: 128, eb: 0};

      // Reset with every input active.
      rst = 1'b1; enable = 1'b1; fade_en = 1'b1;
      led_r_in = 1'b1; led_g_in = 1'b1; led_b_in = 1'b1;
      duty_r = 8'hFF; duty_g = 8'hFF; duty_b = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("reset_outs_%0d", i),
             int'({led_r, led_g, led_b, period_start, fade_busy}), 0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset_outs", int'({led_r, led_g, led_b, period_start, fade_busy}), 0);
      fade_en = 1'b0;

      // Static duty table.
      for (int v = 0; v < 4; v++) begin
         duty_r = vecs[v].dr; duty_g = vecs[v].dg; duty_b = vecs[v].db;
         {led_r_in, led_g_in, led_b_in} = vecs[v].in_rgb;
         wait_ps(n);
         count_period(hr, hg, hb, ps, fr, be);
         chk($sformatf("v%0d_width_r", v), hr, vecs[v].er);
         chk($sformatf("v%0d_width_g", v), hg, vecs[v].eg);
         chk($sformatf("v%0d_width_b", v), hb, vecs[v].eb);
         chk($sformatf("v%0d_ps_per_period", v), ps, 1);
         if (vecs[v].er > 0) chk($sformatf("v%0d_first_high_r", v), fr, 1);
      end
      // Back-to-back period keeps the same widths and cadence.
      count_period(hr, hg, hb, ps, fr, be);
      chk("repeat_width_g", hg, 128);
      chk("repeat_ps", ps, 1);

      // Duty change mid-period waits for the boundary.
      led_r_in = 1'b1; led_g_in = 1'b1; led_b_in = 1'b1;
      duty_b = 8'd32;
      wait_ps(n);
      hb = 0;
      for (int i = 1; i <= 256; i++) begin
         if (i == 100) duty_b = 8'd200;
         @(negedge clk);
         if (led_b) hb++;
      end
      chk("glitchfree_cur_period_b", hb, 32);
      count_period(hr, hg, hb, ps, fr, be);
      chk("glitchfree_next_period_b", hb, 200);

      // Fade ramp up from 0 to 4, then back down to 2.
      duty_r = 8'd0;
      wait_ps(n);
      duty_r = 8'd4; fade_en = 1'b1;
      wait_ps(n);
      for (int k = 0; k < 5; k++) begin
         count_period(hr, hg, hb, ps, fr, be);
         chk($sformatf("fade_up_width_%0d", k), hr, fade_w[k]);
         chk($sformatf("fade_up_busy_%0d", k), be, fade_b[k]);
      end
      duty_r = 8'd2;
      wait_ps(n);
      count_period(hr, hg, hb, ps, fr, be);
      chk("fade_down_width_0", hr, 3);
      chk("fade_down_busy_0", be, 1);
      count_period(hr, hg, hb, ps, fr, be);
      chk("fade_down_width_1", hr, 2);
      chk("fade_down_busy_1", be, 0);

      // Enable drop at pwm_cnt=50, then re-enable.
      fade_en = 1'b0; duty_r = 8'd255; duty_g = 8'd100; duty_b = 8'd10;
      wait_ps(n);
      repeat (50) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      chk("disable_outs", int'({led_r, led_g, led_b}), 0);
      ps = 0; hr = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (period_start) ps++;
         if (led_r || led_g || led_b) hr++;
      end
      chk("disabled_no_ps", ps, 0);
      chk("disabled_leds_low", hr, 0);
      enable = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!period_start && n < 600);
      chk("reenable_first_ps", n, 256);
      count_period(hr, hg, hb, ps, fr, be);
      chk("reenable_width_r", hr, 256);
      chk("reenable_width_g", hg, 100);
      chk("reenable_width_b", hb, 10);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
